// File: rtl/digest_reader_224.sv
// Unloads a captured 224-bit SHA-224 digest as seven 32-bit words over a
// valid/ready handshake, in a selectable word order.
module digest_reader_224 #(
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [223:0] block_in,
    input  logic         word_ready,
    output logic [31:0]  word_out,
    output logic         word_valid,
    output logic         word_last,
    output logic [2:0]   word_idx,
    output logic         busy,
    output logic         done
);

    localparam int unsigned BLOCK_W   = 224;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_WORDS = BLOCK_W / WORD_W;
    localparam int unsigned IDX_W     = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e               state_q;
    logic [BLOCK_W-1:0]   shadow_q;
    logic [IDX_W-1:0]     idx_q;
    logic [WORD_W-1:0]    word_q;
    logic                 valid_q;
    logic                 last_q;
    logic                 busy_q;
    logic                 done_q;
    logic [IDX_W-1:0]     idx_inc_d;

    // Word k of a block in the configured order.
    function automatic logic [WORD_W-1:0] slice_word(input logic [BLOCK_W-1:0] blk,
                                                     input logic [IDX_W-1:0]   k);
        int unsigned pos;
        pos = MSW_FIRST ? (NUM_WORDS - 1 - 32'(k)) : 32'(k);
        return WORD_W'(blk >> (WORD_W * pos));
    endfunction

    assign idx_inc_d = idx_q + IDX_W'(1);

    // word_q always mirrors slice_word(shadow_q, idx_q) so word_out needs no output mux.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        state_q  <= ST_SEND;
                        shadow_q <= block_in;
                        idx_q    <= '0;
                        word_q   <= slice_word(block_in, '0);
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        last_q   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (word_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_IDLE;
                            idx_q   <= '0;
                            word_q  <= slice_word(shadow_q, '0);
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_inc_d;
                            word_q <= slice_word(shadow_q, idx_inc_d);
                            last_q <= (idx_inc_d == LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign word_last  = last_q;
    assign word_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
